replica_exchange_sched: RTL and testbench
=========================================

Name: replica_exchange_sched

Overview:
- Parametrised successor to the fixed-size exchange command path.
- Once per exchange round, collects the total energy of every replica in index order.
- Evaluates Metropolis exchange between adjacent-temperature pairs, alternating even/odd pairing each round.
- Streams one exchange_command_t per replica (SELF/PREV/FOLW) to the replica nodes under valid/ready handshake.

Parameters:
- REPLICA_NUM, 40, number of replicas; any value >= 2, odd allowed.
- E_W, 23, energy width, unsigned fixed point 6.17 (total_data_t).
- DBETA, 5, inverse-temperature step between adjacent replicas.
- THR_W, 32, width of random threshold (r_exchange).
- ID_W, $clog2(REPLICA_NUM), replica index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin round; accepted only in IDLE
- e_valid  in  1  energy beat valid
- e_ready  out  1  high only in LOAD
- e_data  in  E_W  energy of replica at index = beat count
- thr_data  in  THR_W  random threshold, sampled when thr_take=1
- thr_take  out  1  one-cycle pulse per evaluated pair
- cmd_valid  out  1  command valid
- cmd_ready  in  1  consumer ready
- cmd_id  out  ID_W  replica index of cmd
- cmd  out  2  exchange_command_t
- phase  out  1  pairing used by current/next round
- done  out  1  one-cycle pulse after last command accepted
- busy  out  1  high outside IDLE

Behaviour:
- Reset:
  - Async on rst_n=0; FSM to IDLE; phase=0.
  - All outputs 0: cmd=NOP, cmd_id=0, e_ready=0, cmd_valid=0, done=0, thr_take=0, busy=0.
  - Energy buffer and decision bits are not reset.
  - Reset mid-round abandons the round; no done.
- FSM: IDLE -> LOAD -> EVAL -> EMIT -> IDLE.
- IDLE:
  - start=1 -> LOAD, beat counter=0.
  - start in any other state is ignored.
- LOAD:
  - e_ready=1. Each e_valid beat stores E[cnt], cnt++.
  - After beat REPLICA_NUM-1 -> EVAL next cycle.
  - e_valid while e_ready=0 is ignored.
- EVAL, one pair per cycle:
  - phase 0 pairs: (0,1),(2,3),...
  - phase 1 pairs: (1,2),(3,4),...
  - For pair (i,i+1): thr_take=1 and thr_data sampled the same cycle.
  - d = DBETA*(E[i] - E[i+1]) computed signed at E_W+1+$clog2(DBETA+1) bits, no saturation.
  - accept = (d >= 0) OR (|d| < thr_data, zero-extended compare).
  - Decision stored in bit acc[i].
  - Length = number of pairs in the phase: floor(N/2) for phase 0, floor((N-1)/2) for phase 1. After the last pair -> EMIT.
- EMIT:
  - cmd_id counts 0..REPLICA_NUM-1, advancing only on cmd_valid & cmd_ready. cmd/cmd_id hold stable while stalled.
  - cmd for replica j:
    - FOLW if j is the lower member of an accepted pair.
    - PREV if j is the upper member of an accepted pair.
    - SELF otherwise, including unpaired edge replicas: replica 0 in phase 1; last replica when the pairing leaves it out.
  - After the handshake on index REPLICA_NUM-1: done=1 for one cycle, phase toggles, -> IDLE.
  - cmd=NOP whenever cmd_valid=0.
- Latency, no stall: start to first cmd_valid = 1 + REPLICA_NUM + pairs + 1 cycles.
- Boundaries:
  - REPLICA_NUM=2, phase 1: zero pairs; EVAL lasts one cycle with no thr_take; all commands SELF.
  - Equal energies give d=0 -> always accept.

Optional Feature:
- Macro EXCH_STAT_EN.
- Defined: extra outputs acc_cnt (ID_W bits, accepted pairs in the last round, updated with done) and round_cnt (16 bits, wraps at 65535). Both reset to 0.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- N=4, phase 0, E={10,20,30,40}, thr=0 -> d=-50 for both pairs, both reject; cmds SELF x4; done; phase=1.
- N=4, phase 0, E={40,30,20,10}, thr=0 -> both pairs accept; cmds FOLW,PREV,FOLW,PREV.
- N=5, phase 1, E={0,50,10,9,8}, thr=0 -> pairs (1,2) accept, (3,4) accept (d=5); cmds SELF,FOLW,PREV,FOLW,PREV.
- N=4, E={100,101,0,0}, thr=6, then thr=5 on a second run -> pair (0,1) has |d|=5: accept with thr=6, reject with thr=5.
- Hold cmd_ready=0 for 3 cycles mid-EMIT -> cmd and cmd_id stable; no skipped or duplicated index. Start pulses during LOAD are ignored.
- Drop rst_n during EVAL -> all outputs 0 immediately, phase=0. A following full round completes normally with the EXCH_STAT_EN counters correct.

Source files
------------

// File: rtl/replica_exchange_sched.sv
// Replica-exchange command scheduler: loads per-replica energies, runs Metropolis tests on
// alternating adjacent pairs, then streams SELF/PREV/FOLW commands. Optional stats: EXCH_STAT_EN.
module replica_exchange_sched #(
    parameter int REPLICA_NUM = 40,
    parameter int E_W         = 23,
    parameter int DBETA       = 5,
    parameter int THR_W       = 32,
    parameter int ID_W        = $clog2(REPLICA_NUM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             e_valid,
    output logic             e_ready,
    input  logic [E_W-1:0]   e_data,
    input  logic [THR_W-1:0] thr_data,
    output logic             thr_take,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [ID_W-1:0]  cmd_id,
    output logic [1:0]       cmd,
    output logic             phase,
    output logic             done,
    output logic             busy
`ifdef EXCH_STAT_EN
    ,
    output logic [ID_W-1:0]  acc_cnt,
    output logic [15:0]      round_cnt
`endif
);

    localparam int DW  = E_W + 1 + $clog2(DBETA + 1);
    localparam int CW  = (DW > THR_W) ? DW : THR_W;
    localparam int NP0 = REPLICA_NUM / 2;
    localparam int NP1 = (REPLICA_NUM - 1) / 2;

    typedef enum logic [1:0] {CMD_NOP = 2'd0, CMD_SELF = 2'd1, CMD_PREV = 2'd2, CMD_FOLW = 2'd3} cmd_e;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EVAL, S_EMIT} state_e;

    state_e                  state_q;
    logic                    phase_q, e_ready_q, thr_take_q, cmd_valid_q, done_q, busy_q;
    logic [ID_W-1:0]         cnt_q, pair_q, cmd_id_q;
    logic [1:0]              cmd_q;
    logic [REPLICA_NUM-1:0]  acc_q, acc_d;
    logic [E_W-1:0]          e_mem_q [REPLICA_NUM];

    int unsigned             lo_int, np_cur;
    logic [ID_W-1:0]         lo_idx, hi_idx;
    logic [DW-1:0]           diff, d_mag;
    logic signed [DW-1:0]    d_s;
    logic                    accept, last_pair;

    // Lower index of a pair encodes the decision; a bit set means "lower member of an accepted pair".
    function automatic logic [1:0] cmd_of(input int unsigned j, input logic [REPLICA_NUM-1:0] a);
        logic [1:0] r;
        r = CMD_SELF;
        for (int unsigned k = 0; k < REPLICA_NUM; k++) begin
            if (a[k] && k == j)     r = CMD_FOLW;
            if (a[k] && k + 1 == j) r = CMD_PREV;
        end
        return r;
    endfunction

    always_comb begin
        lo_int    = 2 * 32'(pair_q) + 32'(phase_q);
        lo_idx    = ID_W'(lo_int);
        hi_idx    = ID_W'(lo_int + 1);
        diff      = DW'(e_mem_q[lo_idx]) - DW'(e_mem_q[hi_idx]);
        d_s       = $signed(diff) * $signed(DW'(DBETA));
        d_mag     = d_s[DW-1] ? DW'(-d_s) : DW'(d_s);
        accept    = !d_s[DW-1] || (CW'(d_mag) < CW'(thr_data));
        np_cur    = phase_q ? 32'(NP1) : 32'(NP0);
        last_pair = (32'(pair_q) + 1 >= np_cur);
        acc_d     = acc_q;
        for (int unsigned k = 0; k < REPLICA_NUM; k++) begin
            if (state_q == S_EVAL && thr_take_q && k == lo_int) acc_d[k] = accept;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && e_valid) e_mem_q[cnt_q] <= e_data;
        if (state_q == S_IDLE && start) acc_q <= '0;
        else                            acc_q <= acc_d;
    end

`ifdef EXCH_STAT_EN
    int unsigned     n_acc;
    logic [ID_W-1:0] acc_cnt_q;
    logic [15:0]     round_cnt_q;

    always_comb begin
        n_acc = 0;
        for (int unsigned k = 0; k < REPLICA_NUM; k++) n_acc = n_acc + 32'(acc_q[k]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_q   <= '0;
            round_cnt_q <= '0;
        end else if (state_q == S_EMIT && cmd_ready && cmd_id_q == ID_W'(REPLICA_NUM - 1)) begin
            acc_cnt_q   <= ID_W'(n_acc);
            round_cnt_q <= round_cnt_q + 16'd1;
        end
    end

    assign acc_cnt   = acc_cnt_q;
    assign round_cnt = round_cnt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            phase_q     <= 1'b0;
            cnt_q       <= '0;
            pair_q      <= '0;
            e_ready_q   <= 1'b0;
            thr_take_q  <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NOP;
            cmd_id_q    <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_LOAD;
                        cnt_q     <= '0;
                        e_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (e_valid) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == ID_W'(REPLICA_NUM - 1)) begin
                            state_q    <= S_EVAL;
                            e_ready_q  <= 1'b0;
                            pair_q     <= '0;
                            thr_take_q <= (np_cur != 0);
                        end
                    end
                end
                S_EVAL: begin
                    // The first command must see the decision being written this cycle.
                    if (!thr_take_q || last_pair) begin
                        state_q     <= S_EMIT;
                        thr_take_q  <= 1'b0;
                        cmd_valid_q <= 1'b1;
                        cmd_id_q    <= '0;
                        cmd_q       <= cmd_of(0, acc_d);
                    end else begin
                        pair_q <= pair_q + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (cmd_ready) begin
                        if (cmd_id_q == ID_W'(REPLICA_NUM - 1)) begin
                            state_q     <= S_IDLE;
                            cmd_valid_q <= 1'b0;
                            cmd_q       <= CMD_NOP;
                            cmd_id_q    <= '0;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                            phase_q     <= !phase_q;
                        end else begin
                            cmd_id_q <= cmd_id_q + 1'b1;
                            cmd_q    <= cmd_of(32'(cmd_id_q) + 1, acc_q);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign e_ready   = e_ready_q;
    assign thr_take  = thr_take_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign cmd_id    = cmd_id_q;
    assign phase     = phase_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_replica_exchange_sched.sv
// Scoreboard bench for replica_exchange_sched: three instances (N=4, N=5, N=2) driven with
// hand-computed directed rounds; a negedge monitor checks every presented command.
module tb_replica_exchange_sched;
    localparam int E_W   = 23;
    localparam int THR_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             start_a [3];
    logic             e_valid_a [3];
    logic             cmd_ready_a [3];
    logic [E_W-1:0]   e_data_a [3];
    logic [THR_W-1:0] thr_a [3];
    logic             e_ready_a [3];
    logic             thr_take_a [3];
    logic             cmd_valid_a [3];
    logic             phase_a [3];
    logic             done_a [3];
    logic             busy_a [3];
    logic [1:0]       cmd_a [3];
    logic [2:0]       id_a [3];
    logic [1:0]       id4;
    logic [2:0]       id5;
    logic [0:0]       id2;

    assign id_a[0] = 3'(id4);
    assign id_a[1] = id5;
    assign id_a[2] = 3'(id2);

`ifdef EXCH_STAT_EN
    logic [1:0]  ac4;
    logic [2:0]  ac5;
    logic [0:0]  ac2;
    logic [2:0]  ac_a [3];
    logic [15:0] rc_a [3];
    assign ac_a[0] = 3'(ac4);
    assign ac_a[1] = ac5;
    assign ac_a[2] = 3'(ac2);
`endif

    replica_exchange_sched #(.REPLICA_NUM(4), .E_W(E_W), .DBETA(5), .THR_W(THR_W)) u_n4 (
        .clk(clk), .rst_n(rst_n), .start(start_a[0]), .e_valid(e_valid_a[0]), .e_ready(e_ready_a[0]),
        .e_data(e_data_a[0]), .thr_data(thr_a[0]), .thr_take(thr_take_a[0]), .cmd_valid(cmd_valid_a[0]),
        .cmd_ready(cmd_ready_a[0]), .cmd_id(id4), .cmd(cmd_a[0]), .phase(phase_a[0]), .done(done_a[0]),
        .busy(busy_a[0])
`ifdef EXCH_STAT_EN
        , .acc_cnt(ac4), .round_cnt(rc_a[0])
`endif
    );

    replica_exchange_sched #(.REPLICA_NUM(5), .E_W(E_W), .DBETA(5), .THR_W(THR_W)) u_n5 (
        .clk(clk), .rst_n(rst_n), .start(start_a[1]), .e_valid(e_valid_a[1]), .e_ready(e_ready_a[1]),
        .e_data(e_data_a[1]), .thr_data(thr_a[1]), .thr_take(thr_take_a[1]), .cmd_valid(cmd_valid_a[1]),
        .cmd_ready(cmd_ready_a[1]), .cmd_id(id5), .cmd(cmd_a[1]), .phase(phase_a[1]), .done(done_a[1]),
        .busy(busy_a[1])
`ifdef EXCH_STAT_EN
        , .acc_cnt(ac5), .round_cnt(rc_a[1])
`endif
    );

    replica_exchange_sched #(.REPLICA_NUM(2), .E_W(E_W), .DBETA(5), .THR_W(THR_W)) u_n2 (
        .clk(clk), .rst_n(rst_n), .start(start_a[2]), .e_valid(e_valid_a[2]), .e_ready(e_ready_a[2]),
        .e_data(e_data_a[2]), .thr_data(thr_a[2]), .thr_take(thr_take_a[2]), .cmd_valid(cmd_valid_a[2]),
        .cmd_ready(cmd_ready_a[2]), .cmd_id(id2), .cmd(cmd_a[2]), .phase(phase_a[2]), .done(done_a[2]),
        .busy(busy_a[2])
`ifdef EXCH_STAT_EN
        , .acc_cnt(ac2), .round_cnt(rc_a[2])
`endif
    );

    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic [4:0] exp_q [3][$];
    int         thr_cnt [3];
    logic       ph_m [3];
    int         rc_m [3];

    task automatic chk(input string name, input int act, input int req);
        total_cnt++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
    endtask

    // Monitor: every presented command must equal the queue head; pop only when it is accepted.
    initial begin
        logic [4:0] h;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int u = 0; u < 3; u++) begin
                    if (thr_take_a[u]) thr_cnt[u]++;
                    if (cmd_valid_a[u]) begin
                        if (exp_q[u].size() == 0) begin
                            total_cnt++;
                            $display("FAIL cmd_unexpected u%0d actual_id=%0d actual_cmd=%0d required=none",
                                     u, id_a[u], cmd_a[u]);
                        end else begin
                            h = exp_q[u][0];
                            chk($sformatf("cmd_u%0d_id%0d", u, h[4:2]), int'({id_a[u], cmd_a[u]}), int'(h));
                            if (cmd_ready_a[u]) void'(exp_q[u].pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic run_round(input int u, input int n, input int unsigned e0, input int unsigned e1,
                             input int unsigned e2, input int unsigned e3, input int unsigned e4,
                             input logic [31:0] thr, input string exp, input int np, input int stall_at);
        int unsigned ev [5];
        logic [1:0]  code;
        byte         c;
        int          nacc;
        int          k;
        bit          done_seen;
        bit          stalled;
        ev   = '{e0, e1, e2, e3, e4};
        nacc = 0;
        for (int j = 0; j < n; j++) begin
            c    = exp[j];
            code = (c == "F") ? 2'd3 : ((c == "P") ? 2'd2 : 2'd1);
            if (c == "F") nacc++;
            exp_q[u].push_back({3'(j), code});
        end
        thr_a[u]   = thr;
        thr_cnt[u] = 0;
        e_valid_a[u] = 1'b1;
        e_data_a[u]  = '1;
        @(posedge clk) #1;
        start_a[u] = 1'b1;
        @(posedge clk) #1;
        start_a[u] = 1'b0;
        chk($sformatf("e_ready_load_u%0d", u), int'(e_ready_a[u]), 1);
        for (int b = 0; b < n; b++) begin
            e_data_a[u]  = E_W'(ev[b]);
            e_valid_a[u] = 1'b1;
            start_a[u]   = (b == 1);
            @(posedge clk) #1;
        end
        e_valid_a[u] = 1'b0;
        start_a[u]   = 1'b0;
        k = 0;
        done_seen = 1'b0;
        stalled   = 1'b0;
        while (!done_seen && k < 300) begin
            if (stall_at >= 0 && !stalled && cmd_valid_a[u] && int'(id_a[u]) == stall_at) begin
                cmd_ready_a[u] = 1'b0;
                repeat (3) @(posedge clk) #1;
                cmd_ready_a[u] = 1'b1;
                stalled = 1'b1;
            end
            @(posedge clk) #1;
            k++;
            if (done_a[u]) done_seen = 1'b1;
        end
        chk($sformatf("done_seen_u%0d", u), int'(done_seen), 1);
        chk($sformatf("cmd_nop_after_u%0d", u), int'({cmd_valid_a[u], cmd_a[u]}), 0);
        ph_m[u] = !ph_m[u];
        chk($sformatf("phase_u%0d", u), int'(phase_a[u]), int'(ph_m[u]));
        chk($sformatf("thr_take_cnt_u%0d", u), thr_cnt[u], np);
        chk($sformatf("cmds_left_u%0d", u), exp_q[u].size(), 0);
`ifdef EXCH_STAT_EN
        rc_m[u]++;
        chk($sformatf("acc_cnt_u%0d", u), int'(ac_a[u]), nacc);
        chk($sformatf("round_cnt_u%0d", u), int'(rc_a[u]), rc_m[u]);
`endif
        @(posedge clk) #1;
        chk($sformatf("done_pulse_u%0d", u), int'({done_a[u], busy_a[u]}), 0);
        exp_q[u].delete();
    endtask

    initial begin
        int k;
        for (int u = 0; u < 3; u++) begin
            start_a[u] = 1'b0; e_valid_a[u] = 1'b0; cmd_ready_a[u] = 1'b1;
            e_data_a[u] = '0; thr_a[u] = '0; thr_cnt[u] = 0; ph_m[u] = 1'b0; rc_m[u] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_e_ready", int'(e_ready_a[0]), 0);
        chk("rst_cmd_valid", int'(cmd_valid_a[0]), 0);
        chk("rst_cmd", int'(cmd_a[0]), 0);
        chk("rst_cmd_id", int'(id_a[0]), 0);
        chk("rst_done_busy_thr", int'({done_a[0], busy_a[0], thr_take_a[0]}), 0);
        chk("rst_phase", int'(phase_a[0]), 0);
        rst_n = 1'b1;
        @(posedge clk) #1;

        run_round(0, 4, 10, 20, 30, 40, 0, 0, "SSSS", 2, -1);
        run_round(0, 4, 0, 0, 0, 0, 0, 0, "SFPS", 1, -1);
        run_round(0, 4, 40, 30, 20, 10, 0, 0, "FPFP", 2, 2);
        run_round(0, 4, 100, 101, 0, 0, 0, 6, "SFPS", 1, -1);
        run_round(0, 4, 100, 101, 0, 0, 0, 6, "FPFP", 2, -1);
        run_round(0, 4, 100, 101, 0, 0, 0, 5, "SFPS", 1, -1);
        run_round(0, 4, 100, 101, 0, 0, 0, 5, "SSFP", 2, -1);
        run_round(1, 5, 0, 50, 10, 9, 8, 0, "SSFPS", 2, -1);
        run_round(1, 5, 0, 50, 10, 9, 8, 0, "SFPFP", 2, 3);
        run_round(2, 2, 3, 3, 0, 0, 0, 0, "FP", 1, -1);
        run_round(2, 2, 3, 7, 0, 0, 0, 0, "SS", 0, 0);

        // Abandon a round in EVAL via reset.
        thr_a[0] = '0;
        start_a[0] = 1'b1;
        @(posedge clk) #1;
        start_a[0] = 1'b0;
        for (int b = 0; b < 4; b++) begin
            e_data_a[0] = E_W'(b + 1);
            e_valid_a[0] = 1'b1;
            @(posedge clk) #1;
        end
        e_valid_a[0] = 1'b0;
        k = 0;
        while (!thr_take_a[0] && k < 20) begin
            @(posedge clk) #1;
            k++;
        end
        chk("reach_eval", int'(thr_take_a[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_e_ready", int'(e_ready_a[0]), 0);
        chk("mid_rst_thr_take", int'(thr_take_a[0]), 0);
        chk("mid_rst_cmd_valid", int'(cmd_valid_a[0]), 0);
        chk("mid_rst_cmd", int'(cmd_a[0]), 0);
        chk("mid_rst_cmd_id", int'(id_a[0]), 0);
        chk("mid_rst_done_busy", int'({done_a[0], busy_a[0]}), 0);
        chk("mid_rst_phase_n4", int'(phase_a[0]), 0);
        chk("mid_rst_phase_n5", int'(phase_a[1]), 0);
        for (int u = 0; u < 3; u++) begin
            ph_m[u] = 1'b0;
            rc_m[u] = 0;
        end
        @(posedge clk) #1;
        rst_n = 1'b1;
        @(posedge clk) #1;
        run_round(0, 4, 40, 30, 20, 10, 0, 0, "FPFP", 2, -1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
